lsu_wb_master: RTL and testbench

- Load/store unit that sits between the core's memory stage and the word-only Wishbone memory slave. It drives that slave's cyc/stb/we/addr/data and consumes its ack and read data.
- The slave has no byte selects, so sub-word stores are performed as read-modify-write.
- Loads are extracted and sign/zero-extended here.
- Adds misalignment detection and a bus timeout watchdog.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_lane_unit.sv | 26 ++
 rtl/lsu_wb_master.sv | 123 ++++++++++++
 tb/tb_lsu_wb_master.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and the alignment rule for the Wishbone load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RMW_WR, RESP, RESP_ERR} state_e;

    // Size code 2'b11 behaves like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size == SZ_HALF) ? addr[0] : size[1] ? |addr : 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: byte-lane load extraction/extension and sub-word store merge.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  sh;
    logic [31:0] lane, mask;

    // Alignment is checked upstream, so the byte shift also places a half on its lane.
    assign sh      = {lane_i, 3'b000};
    assign lane    = rd_word_i >> sh;
    assign mask    = ((size_i == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merge_o = (rd_word_i & ~mask) | ((wdata_i << sh) & mask);
    assign load_o  = (size_i == SZ_BYTE) ? {{24{~unsigned_i & lane[7]}}, lane[7:0]} :
                     (size_i == SZ_HALF) ? {{16{~unsigned_i & lane[15]}}, lane[15:0]} :
                     rd_word_i;

endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: load/store FSM driving a word-only Wishbone slave, with
// read-modify-write sub-word stores, misalignment abort and ack watchdog.
module lsu_wb_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [31:0]           wb_data_o,
    input  logic [31:0]           wb_data_i,
    input  logic                  wb_ack_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d, to_q, to_d;
    logic [31:0]           data_q, data_d, rdata_q, rdata_d, cnt_q, cnt_d;
    logic [31:0]           ld_word, merged;
    logic                  timeout;

    lsu_lane_unit u_lane (
        .rd_word_i  (wb_data_i),
        .wdata_i    (data_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (ld_word),
        .merge_o    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            to_q    <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            to_q    <= to_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && !wb_ack_i && (cnt_q + 32'd1 == 32'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        to_d    = to_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_i) begin
                addr_d  = addr_i;
                size_d  = size_i;
                uns_d   = unsigned_i;
                data_d  = wdata_i;
                to_d    = 1'b0;
                cnt_d   = '0;
                rdata_d = is_misaligned(size_i, addr_i[1:0]) ? '0 : rdata_q;
                state_d = is_misaligned(size_i, addr_i[1:0]) ? RESP_ERR :
                          !we_i ? RD : size_i[1] ? WR : RMW_RD;
            end
            RD, RMW_RD, WR, RMW_WR: if (wb_ack_i) begin
                state_d = (state_q == RMW_RD) ? RMW_WR : RESP;
                data_d  = (state_q == RMW_RD) ? merged : data_q;
                rdata_d = (state_q == RD) ? ld_word : (state_q == RMW_RD) ? rdata_q : '0;
                cnt_d   = '0;
            end else if (timeout) begin
                state_d = RESP_ERR;
                to_d    = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = state_q != IDLE;
        wb_we_o      = (state_q == WR) || (state_q == RMW_WR);
        wb_cyc_o     = wb_we_o || (state_q == RD) || (state_q == RMW_RD);
        wb_stb_o     = wb_cyc_o;
        wb_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        wb_data_o    = wb_we_o ? data_q : '0;
        done_o       = (state_q == RESP) || (state_q == RESP_ERR);
        misaligned_o = (state_q == RESP_ERR) && !to_q;
        err_o        = (state_q == RESP_ERR) && to_q;
        rdata_o      = rdata_q;
    end

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: directed checks of lsu_wb_master against a zero-latency word memory.
module tb_lsu_wb_master;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [31:0] rdata_o, wb_addr_o, wb_data_o, wb_data_i;
    logic        done_o, misaligned_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic        ack_en = 1'b1;
    logic [31:0] mem [0:15];
    int          nr = 0, nw = 0, ncyc = 0, nwe = 0;
    logic [31:0] last_wd = '0;
    int          checks = 0, fails = 0;
    int          lat, d_nr, d_nw, d_cyc, d_we;
    logic [31:0] rd;
    logic        mis, er;

    always #5 clk = ~clk;

    lsu_wb_master #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .done_o(done_o), .misaligned_o(misaligned_o), .err_o(err_o), .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    assign wb_ack_i  = ack_en & wb_cyc_o & wb_stb_o;
    assign wb_data_i = mem[wb_addr_o[5:2]];

    always @(posedge clk) begin
        if (wb_cyc_o) ncyc <= ncyc + 1;
        if (wb_we_o) nwe <= nwe + 1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            if (wb_we_o) begin
                nw <= nw + 1;
                last_wd <= wb_data_o;
                mem[wb_addr_o[5:2]] <= wb_data_o;
            end else begin
                nr <= nr + 1;
            end
        end
    end

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
        int r0, w0, c0, e0;
        @(negedge clk);
        r0 = nr; w0 = nw; c0 = ncyc; e0 = nwe;
        we_i = w; size_i = sz; unsigned_i = u; addr_i = a; wdata_i = d; req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (done_o) begin
                lat = i; rd = rdata_o; mis = misaligned_o; er = err_o;
            end
        end
        d_nr = nr - r0; d_nw = nw - w0; d_cyc = ncyc - c0; d_we = nwe - e0;
        checks++;
        if (lat == 0) begin
            fails++;
            $display("FAIL op_done_timeout addr=%h got no done_o within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rdata_o, done_o, misaligned_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got rdata=%h done=%b cyc=%b addr=%h exp all zero", rdata_o, done_o, wb_cyc_o, wb_addr_o);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [1:0]  sz [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        un [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] ex [6] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        for (int k = 0; k < 6; k++) begin
            op(1'b0, sz[k], un[k], ad[k], 32'h0);
            checks++;
            if (rd !== ex[k]) begin fails++; $display("FAIL load%0d rdata got %h exp %h", k, rd, ex[k]); end
            checks++;
            if (lat != 2) begin fails++; $display("FAIL load%0d latency got %0d exp 2", k, lat); end
            checks++;
            if (d_nr != 1 || d_nw != 0 || mis || er) begin
                fails++; $display("FAIL load%0d beats got rd=%0d wr=%0d mis=%b err=%b exp 1 0 0 0", k, d_nr, d_nw, mis, er);
            end
        end
        @(negedge clk);
        checks++;
        if (rdata_o !== 32'h80FF7F01 || done_o !== 1'b0) begin
            fails++; $display("FAIL rdata_hold got %h done=%b exp 80ff7f01 done=0", rdata_o, done_o);
        end
    endtask

    task automatic test_sub_word_store();
        op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
        checks++;
        if (lat != 3) begin fails++; $display("FAIL sb_latency got %0d exp 3", lat); end
        checks++;
        if (d_nr != 1 || d_nw != 1) begin fails++; $display("FAIL sb_beats got rd=%0d wr=%0d exp 1 1", d_nr, d_nw); end
        checks++;
        if (last_wd !== 32'h80FFAB01) begin fails++; $display("FAIL sb_wdata got %h exp 80ffab01", last_wd); end
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL sb_rdata got %h exp 00000000", rd); end
        op(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
        checks++;
        if (lat != 3 || mem[4] !== 32'h1234AB01) begin
            fails++; $display("FAIL sh_mem got lat=%0d mem=%h exp lat=3 mem=1234ab01", lat, mem[4]);
        end
    endtask

    task automatic test_word_store();
        op(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        checks++;
        if (lat != 2 || d_nr != 0 || d_nw != 1) begin
            fails++; $display("FAIL sw_beats got lat=%0d rd=%0d wr=%0d exp 2 0 1", lat, d_nr, d_nw);
        end
        checks++;
        if (mem[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem got %h exp deadbeef", mem[5]); end
    endtask

    task automatic test_misaligned();
        op(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        checks++;
        if (lat != 1 || !mis || er || d_cyc != 0) begin
            fails++; $display("FAIL mis_lw got lat=%0d mis=%b err=%b cyc=%0d exp 1 1 0 0", lat, mis, er, d_cyc);
        end
        op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        checks++;
        if (lat != 1 || !mis || er || d_cyc != 0) begin
            fails++; $display("FAIL mis_lh got lat=%0d mis=%b err=%b cyc=%0d exp 1 1 0 0", lat, mis, er, d_cyc);
        end
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat != 17 || !er || mis || d_cyc != 16) begin
            fails++; $display("FAIL to_load got lat=%0d err=%b mis=%b cyc=%0d exp 17 1 0 16", lat, er, mis, d_cyc);
        end
        op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000EE);
        checks++;
        if (lat != 17 || !er || d_cyc != 16 || d_we != 0) begin
            fails++; $display("FAIL to_sb got lat=%0d err=%b cyc=%0d we_cycles=%0d exp 17 1 16 0", lat, er, d_cyc, d_we);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h11; wdata_i = 32'hCD; req_i = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wb_we_o !== 1'b1) begin fails++; $display("FAIL rst_mid_state got we=%b exp 1", wb_we_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            fails++; $display("FAIL rst_mid_drop got cyc=%b stb=%b exp 0 0", wb_cyc_o, wb_stb_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b exp 0", done_o); end
        end
        rst = 1'b0;
        op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat != 2 || rd !== 32'h1234AB01) begin
            fails++; $display("FAIL rst_mid_lw got lat=%0d rdata=%h exp 2 1234ab01", lat, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h80FF7F01;
        test_reset();
        test_loads();
        test_sub_word_store();
        test_word_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
